// File: rtl/sccb_target.sv
// SCCB target: three-phase write / two-phase read slave with a
// 256x8 register file, oversampling SIO_C/SIO_D on the system clock.
module sccb_target #(
    parameter logic [7:0] P_ID   = 8'h42,
    parameter int          P_SYNC = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_SIO_C,
    input  logic       i_SIO_D,
    output logic       o_SIO_D_Out,
    output logic       o_SIO_D_Oe,
    output logic       o_Wr_fValid,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Busy,
    output logic       o_Err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID,
        S_SUBADDR,
        S_WDATA,
        S_RDATA,
        S_WAIT_STOP
    } state_t;

    localparam logic [7:0] RD_ID = P_ID | 8'h01;

    logic [P_SYNC-1:0] c_sync;
    logic [P_SYNC-1:0] d_sync;
    logic              c_s;
    logic              d_s;
    logic              c_d;
    logic              d_d;

    logic              c_rise;
    logic              c_fall;
    logic              d_rise;
    logic              d_fall;
    logic              start;
    logic              stop;
    logic              phase_end;
    logic              wr_en;

    state_t            state;
    logic [3:0]        cnt;
    logic [7:0]        shreg;
    logic [7:0]        sub_addr;
    logic [7:0]        rd_byte;
    logic [7:0]        mem [256];

    // Bring both bus lines into the clock domain; idle bus level is high
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            c_sync <= '1;
            d_sync <= '1;
        end else begin
            c_sync <= {c_sync[P_SYNC-2:0], i_SIO_C};
            d_sync <= {d_sync[P_SYNC-2:0], i_SIO_D};
        end
    end

    assign c_s = c_sync[P_SYNC-1];
    assign d_s = d_sync[P_SYNC-1];

    // Delayed copies of the synchronized lines for edge detection
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            c_d <= 1'b1;
            d_d <= 1'b1;
        end else begin
            c_d <= c_s;
            d_d <= d_s;
        end
    end

    assign c_rise = c_s & ~c_d;
    assign c_fall = ~c_s & c_d;
    assign d_rise = d_s & ~d_d;
    assign d_fall = ~d_s & d_d;

    // SIO_C must be stable high across the data edge, so a clock edge in
    // the same cycle suppresses START/STOP.
    assign start = c_s & c_d & d_fall;
    assign stop  = c_s & c_d & d_rise;

    // The ninth rising edge of a phase closes the byte
    assign phase_end = c_rise && (cnt == 4'd8);
    assign wr_en     = phase_end && (state == S_WDATA);

    // Register file, cleared entirely by reset
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[sub_addr] <= shreg;
        end
    end

    // Protocol FSM: bit counting, phase decode and registered outputs
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            shreg       <= '0;
            sub_addr    <= '0;
            rd_byte     <= '0;
            o_SIO_D_Out <= 1'b0;
            o_SIO_D_Oe  <= 1'b0;
            o_Wr_fValid <= 1'b0;
            o_Wr_Addr   <= '0;
            o_Wr_Data   <= '0;
            o_Busy      <= 1'b0;
            o_Err       <= 1'b0;
        end else begin
            o_Wr_fValid <= 1'b0;
            o_Err       <= 1'b0;
            if (start) begin
                state       <= S_ID;
                cnt         <= '0;
                o_SIO_D_Oe  <= 1'b0;
                o_SIO_D_Out <= 1'b0;
                o_Busy      <= 1'b1;
            end else if (stop) begin
                state       <= S_IDLE;
                cnt         <= '0;
                o_SIO_D_Oe  <= 1'b0;
                o_SIO_D_Out <= 1'b0;
                o_Busy      <= 1'b0;
            end else begin
                // Read data changes while SIO_C is low; the NA bit is released
                if (c_fall && state == S_RDATA) begin
                    if (cnt < 4'd8) begin
                        o_SIO_D_Oe  <= 1'b1;
                        o_SIO_D_Out <= rd_byte[~cnt[2:0]];
                    end else begin
                        o_SIO_D_Oe  <= 1'b0;
                        o_SIO_D_Out <= 1'b0;
                    end
                end
                if (c_rise) begin
                    if (cnt == 4'd8) begin
                        cnt <= '0;
                        unique case (state)
                            S_ID: begin
                                if (shreg == P_ID) begin
                                    state <= S_SUBADDR;
                                end else if (shreg == RD_ID) begin
                                    state   <= S_RDATA;
                                    rd_byte <= mem[sub_addr];
                                end else begin
                                    state <= S_WAIT_STOP;
                                    o_Err <= 1'b1;
                                end
                            end
                            S_SUBADDR: begin
                                sub_addr <= shreg;
                                state    <= S_WDATA;
                            end
                            S_WDATA: begin
                                o_Wr_fValid <= 1'b1;
                                o_Wr_Addr   <= sub_addr;
                                o_Wr_Data   <= shreg;
                                state       <= S_WAIT_STOP;
                            end
                            S_RDATA: begin
                                state <= S_WAIT_STOP;
                            end
                            default: begin
                                state <= state;
                            end
                        endcase
                    end else begin
                        cnt   <= cnt + 4'd1;
                        shreg <= {shreg[6:0], d_s};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: bus-level SCCB initiator model with
// hand-computed expectations per scenario.
module tb_sccb_target;

    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sio_c;
    logic       m_d;
    logic       bus_d;
    logic       d_out;
    logic       d_oe;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       err;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    int oe_cnt = 0;

    assign bus_d = d_oe ? d_out : m_d;

    always #5 clk = ~clk;

    sccb_target #(.P_ID(8'h42), .P_SYNC(2)) dut (
        .i_Clk       (clk),
        .i_Rst       (rst_n),
        .i_SIO_C     (sio_c),
        .i_SIO_D     (bus_d),
        .o_SIO_D_Out (d_out),
        .o_SIO_D_Oe  (d_oe),
        .o_Wr_fValid (wr_valid),
        .o_Wr_Addr   (wr_addr),
        .o_Wr_Data   (wr_data),
        .o_Busy      (busy),
        .o_Err       (err)
    );

    always @(negedge clk) begin
        if (wr_valid) wr_cnt++;
        if (err) err_cnt++;
        if (d_oe) oe_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_d = 1'b0;
        tick(2 * Q);
        sio_c = 1'b0;
        tick(Q);
    endtask

    task automatic bus_rstart();
        m_d = 1'b1;
        tick(Q);
        sio_c = 1'b1;
        tick(Q);
        m_d = 1'b0;
        tick(Q);
        sio_c = 1'b0;
        tick(Q);
    endtask

    task automatic bus_stop();
        m_d = 1'b0;
        tick(Q);
        sio_c = 1'b1;
        tick(2 * Q);
        m_d = 1'b1;
        tick(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        tick(Q);
        m_d = b;
        tick(Q);
        sio_c = 1'b1;
        tick(2 * Q);
        sio_c = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(1'b1);
    endtask

    task automatic read_byte(output logic [7:0] v, output logic oe_ok,
                             output logic na_oe);
        oe_ok = 1'b1;
        v = '0;
        for (int i = 7; i >= 0; i--) begin
            tick(Q);
            m_d = 1'b1;
            tick(Q);
            sio_c = 1'b1;
            v[i] = bus_d;
            if (d_oe !== 1'b1) oe_ok = 1'b0;
            tick(2 * Q);
            sio_c = 1'b0;
        end
        tick(Q);
        m_d = 1'b1;
        tick(Q);
        sio_c = 1'b1;
        na_oe = d_oe;
        tick(2 * Q);
        sio_c = 1'b0;
    endtask

    task automatic read_addr(input logic [7:0] a, output logic [7:0] v);
        logic ok;
        logic na;
        bus_start();
        send_byte(8'h42);
        send_byte(a);
        bus_stop();
        bus_start();
        send_byte(8'h43);
        read_byte(v, ok, na);
        bus_stop();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sio_c = 1'b1;
        m_d = 1'b1;
        tick(3);
        tests++;
        if ({d_out, d_oe, wr_valid, busy, err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {d_out, d_oe, wr_valid, busy, err});
        end
        tests++;
        if ({wr_addr, wr_data} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_addr_data: got %h expected 0000",
                     {wr_addr, wr_data});
        end
        rst_n = 1'b1;
        tick(4);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_write();
        int lat;
        logic [7:0] d;
        wr_cnt = 0;
        d = 8'h80;
        bus_start();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL start_busy: got %b expected 1", busy);
        end
        send_byte(8'h42);
        send_byte(8'h12);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        tick(Q);
        m_d = 1'b1;
        tick(Q);
        sio_c = 1'b1;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            if (lat == 0) begin
                @(posedge clk);
                #1;
                if (wr_valid) lat = n;
            end
        end
        tests++;
        if (lat != 3) begin
            fails++;
            $display("FAIL wr_latency: got %0d expected 3", lat);
        end
        tests++;
        if (wr_addr !== 8'h12 || wr_data !== 8'h80) begin
            fails++;
            $display("FAIL wr_fields: got %h/%h expected 12/80",
                     wr_addr, wr_data);
        end
        tick(2 * Q);
        sio_c = 1'b0;
        bus_stop();
        tests++;
        if (wr_cnt != 1) begin
            fails++;
            $display("FAIL wr_pulses: got %0d expected 1", wr_cnt);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL stop_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_read();
        logic [7:0] v;
        logic ok;
        logic na;
        wr_cnt = 0;
        bus_start();
        send_byte(8'h42);
        send_byte(8'h12);
        bus_stop();
        bus_start();
        send_byte(8'h43);
        read_byte(v, ok, na);
        bus_stop();
        tests++;
        if (v !== 8'h80) begin
            fails++;
            $display("FAIL rd_data: got %h expected 80", v);
        end
        tests++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL rd_oe: got %b expected 1", ok);
        end
        tests++;
        if (na !== 1'b0) begin
            fails++;
            $display("FAIL rd_na_oe: got %b expected 0", na);
        end
        tests++;
        if (wr_cnt != 0) begin
            fails++;
            $display("FAIL rd_no_write: got %0d expected 0", wr_cnt);
        end
        bus_start();
        send_byte(8'h43);
        read_byte(v, ok, na);
        bus_stop();
        tests++;
        if (v !== 8'h80) begin
            fails++;
            $display("FAIL rd_no_incr: got %h expected 80", v);
        end
    endtask

    task automatic test_bad_id();
        logic [7:0] v;
        wr_cnt = 0;
        err_cnt = 0;
        oe_cnt = 0;
        bus_start();
        send_byte(8'h60);
        send_byte(8'h12);
        send_byte(8'h55);
        bus_stop();
        tests++;
        if (err_cnt != 1) begin
            fails++;
            $display("FAIL bad_id_err: got %0d expected 1", err_cnt);
        end
        tests++;
        if (wr_cnt != 0 || oe_cnt != 0) begin
            fails++;
            $display("FAIL bad_id_quiet: got wr=%0d oe=%0d expected 0/0",
                     wr_cnt, oe_cnt);
        end
        read_addr(8'h12, v);
        tests++;
        if (v !== 8'h80) begin
            fails++;
            $display("FAIL bad_id_keep: got %h expected 80", v);
        end
    endtask

    task automatic test_abort();
        logic [7:0] v;
        wr_cnt = 0;
        bus_start();
        send_byte(8'h42);
        send_byte(8'h12);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_stop();
        tests++;
        if (wr_cnt != 0) begin
            fails++;
            $display("FAIL abort_pulse: got %0d expected 0", wr_cnt);
        end
        read_addr(8'h12, v);
        tests++;
        if (v !== 8'h80) begin
            fails++;
            $display("FAIL abort_keep: got %h expected 80", v);
        end
    endtask

    task automatic test_rstart();
        logic [7:0] v;
        wr_cnt = 0;
        bus_start();
        send_byte(8'h42);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        bus_rstart();
        send_byte(8'h42);
        send_byte(8'h34);
        send_byte(8'hA5);
        bus_stop();
        tests++;
        if (wr_cnt != 1) begin
            fails++;
            $display("FAIL rstart_pulses: got %0d expected 1", wr_cnt);
        end
        tests++;
        if (wr_addr !== 8'h34 || wr_data !== 8'hA5) begin
            fails++;
            $display("FAIL rstart_fields: got %h/%h expected 34/A5",
                     wr_addr, wr_data);
        end
        read_addr(8'h34, v);
        tests++;
        if (v !== 8'hA5) begin
            fails++;
            $display("FAIL rstart_read: got %h expected A5", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        wr_cnt = 0;
        bus_start();
        send_byte(8'h42);
        send_byte(8'h12);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        tick(Q);
        sio_c = 1'b1;
        tick(2);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_busy: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({d_out, d_oe, wr_valid, busy, err} !== 5'b0 ||
            {wr_addr, wr_data} !== 16'h0000) begin
            fails++;
            $display("FAIL async_reset: got %b %h%h expected 00000 0000",
                     {d_out, d_oe, wr_valid, busy, err}, wr_addr, wr_data);
        end
        sio_c = 1'b1;
        m_d = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        tests++;
        if (wr_cnt != 0) begin
            fails++;
            $display("FAIL mid_pulse: got %0d expected 0", wr_cnt);
        end
        read_addr(8'h12, v);
        tests++;
        if (v !== 8'h00) begin
            fails++;
            $display("FAIL clr_12: got %h expected 00", v);
        end
        read_addr(8'h34, v);
        tests++;
        if (v !== 8'h00) begin
            fails++;
            $display("FAIL clr_34: got %h expected 00", v);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        sio_c = 1'b1;
        m_d = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_bad_id();
        test_abort();
        test_rstart();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sccb_target.md
SCCB_TARGET -- requirements
Module: sccb_target

Interface
REQ-001 P_ID, 8'h42, 7-bit device ID in [7:1] with write marker [0]=0; read ID is P_ID|8'h01.
REQ-002 P_SYNC, 2, number of synchronizer flops on i_SIO_C and i_SIO_D; minimum value is 2.
REQ-003 i_Clk  in  1  system clock; frequency SHALL be at least 8x the SIO_C frequency.
REQ-004 i_Rst  in  1  asynchronous, active-low reset.
REQ-005 i_SIO_C  in  1  SCCB clock from the initiator; asynchronous to i_Clk.
REQ-006 i_SIO_D  in  1  SCCB data line as resolved on the bus; asynchronous to i_Clk.
REQ-007 o_SIO_D_Out  out  1  data driven by the target during a read data phase.
REQ-008 o_SIO_D_Oe  out  1  1 = target drives o_SIO_D_Out onto the bus.
REQ-009 o_Wr_fValid  out  1  one-cycle pulse marking a completed 3-phase write.
REQ-010 o_Wr_Addr  out  8  sub-address of the last completed write; held until the next write.
REQ-011 o_Wr_Data  out  8  data of the last completed write; held until the next write.
REQ-012 o_Busy  out  1  high from a detected START until the following STOP.
REQ-013 o_Err  out  1  one-cycle pulse on an ID mismatch.

Function
REQ-014 Synchronization: i_SIO_C and i_SIO_D SHALL each pass through P_SYNC flops before use.
REQ-015 Edge detection: the synchronized lines SHALL be compared against a further registered copy to detect edges.
REQ-016 START: synchronized SIO_D falls while synchronized SIO_C is high. STOP: synchronized SIO_D rises while SIO_C is high.
REQ-017 If SIO_C and SIO_D change in the same i_Clk cycle, no START or STOP is detected.
REQ-018 Bit sampling: a bit is sampled from synchronized SIO_D on each synchronized SIO_C rising edge.
REQ-019 Phase format: each phase is 9 bits, MSB first; bit 9 is the don't-care/NA bit; a 4-bit counter runs 0..8 and clears at each phase end.
REQ-020 States: IDLE, ID, SUBADDR, WDATA, RDATA, WAIT_STOP.
REQ-021 Transition: START from any state goes to ID with the counter cleared; this also covers repeated START.
REQ-022 Transition: ID==P_ID goes to SUBADDR; ID==P_ID|1 goes to RDATA; any other ID pulses o_Err and goes to WAIT_STOP.
REQ-023 Transition: SUBADDR end latches an internal sub-address register, then goes to WDATA.
REQ-024 Transition: WDATA end goes to WAIT_STOP.
REQ-025 Transition: RDATA end goes to WAIT_STOP.
REQ-026 Transition: STOP from any state goes to IDLE.
REQ-027 A STOP after SUBADDR only (2-phase write) SHALL leave the sub-address latched for a following read.
REQ-028 Storage: an internal 256x8 register file is written at WDATA bit 9 with the sampled byte at the latched sub-address.
REQ-029 In the same cycle as that write, o_Wr_fValid pulses and o_Wr_Addr/o_Wr_Data update.
REQ-030 Write latency: o_Wr_fValid SHALL assert P_SYNC+1 i_Clk cycles after the raw i_SIO_C rise of WDATA bit 9.
REQ-031 Read: in RDATA, reg[sub-address] is loaded at the ID phase end.
REQ-032 Read: on each synchronized SIO_C falling edge for bits 1..8, o_SIO_D_Out presents the next bit MSB-first with o_SIO_D_Oe=1.
REQ-033 Read: o_SIO_D_Oe SHALL drop to 0 on the falling edge that begins bit 9 (NA), which the initiator drives.
REQ-034 o_SIO_D_Oe SHALL be 0 in every state other than RDATA bits 1..8.
REQ-035 Abort: a START or STOP before bit 9 of any phase SHALL discard the partial byte; no write or pulse occurs.
REQ-036 No auto-increment: consecutive reads return the same sub-address.

Reset
REQ-037 i_Rst low SHALL asynchronously force state IDLE, counters 0, all outputs 0, latched sub-address 0, and every register-file entry 0.
REQ-038 Reset mid-transaction SHALL discard that transaction; the first START after release is decoded normally.

Verification
REQ-039 3-phase write 0x42,0x12,0x80 -> exactly one o_Wr_fValid; o_Wr_Addr=0x12, o_Wr_Data=0x80; o_Busy falls after STOP.
REQ-040 The scenario of REQ-039, then 2-phase write 0x42,0x12, then 2-phase read 0x43 -> o_SIO_D_Out=1,0,0,0,0,0,0,0 with Oe=1 for 8 bits and Oe=0 at bit 9.
REQ-041 ID 0x60,0x12,0x55 -> one o_Err pulse, no o_Wr_fValid, Oe stays 0, reg[0x12] unchanged.
REQ-042 0x42,0x12 then STOP after 4 WDATA bits -> no o_Wr_fValid; a following read of 0x12 returns the prior value.
REQ-043 Repeated START inside SUBADDR, then full write 0x42,0x34,0xA5 -> single pulse with Addr=0x34, Data=0xA5.
REQ-044 i_Rst low during a WDATA phase -> all outputs 0 immediately; a read of any address after release returns 0x00.
